disp_fmt: RTL and testbench

DISP_FMT -- requirements
Module: disp_fmt

---
 rtl/disp_fmt.sv | 137 +++++++++++++
 tb/tb_disp_fmt.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/disp_fmt.sv
// Signed four-digit display formatter: binary magnitude to digit codes via a
// serial double-dabble conversion, then blanking, minus sign and decimal point.
module disp_fmt #(
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [13:0] value,
    input  logic        neg,
    input  logic [1:0]  frac_pos,
    output logic        busy,
    output logic        done,
    output logic [15:0] bcd,
    output logic [3:0]  dp,
    output logic        frac,
    output logic        ovf
);

    typedef enum logic [1:0] {StIdle, StConv, StFmt} state_e;

    state_e      state_q, state_d;
    logic [13:0] val_q;
    logic        neg_q;
    logic [1:0]  frac_pos_q;
    logic [15:0] sr_q, sr_next;
    logic [3:0]  cnt_q;
    logic        busy_q, done_q, frac_q, ovf_q;
    logic [15:0] bcd_q;
    logic [3:0]  dp_q;

    // Formatted result, built from the finished shift register and latched inputs
    logic [15:0] fmt_bcd;
    logic [3:0]  fmt_dp;
    logic        fmt_frac, fmt_ovf, neg_eff;
    logic [1:0]  top, keep;
    logic [15:0] adj;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StConv;
            StConv:  if (cnt_q == 4'd13) state_d = StFmt;
            StFmt:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // One double-dabble step: add-3 correction, then shift in the next value bit
    always_comb begin
        adj = sr_q;
        for (int i = 0; i < 4; i++) begin
            if (sr_q[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = sr_q[i*4 +: 4] + 4'd3;
        end
        sr_next = {adj[14:0], val_q[4'd13 - cnt_q]};
    end

    always_comb begin
        fmt_ovf = (val_q > 14'd9999) || (neg_q && val_q > 14'd999) ||
                  (neg_q && val_q != 14'd0 && frac_pos_q == 2'd3);
        neg_eff = neg_q && (val_q != 14'd0);
        top = 2'd0;
        for (int i = 1; i < 4; i++) begin
            if (sr_q[i*4 +: 4] != 4'd0) top = i[1:0];
        end
        keep = (top > frac_pos_q) ? top : frac_pos_q;
        fmt_bcd = sr_q;
        if (BLANK_LZ) begin
            for (int i = 0; i < 4; i++) begin
                if (i > int'(keep)) fmt_bcd[i*4 +: 4] = 4'hA;
                if (neg_eff && i == int'(keep) + 1) fmt_bcd[i*4 +: 4] = 4'hB;
            end
        end else if (neg_eff) begin
            fmt_bcd[15:12] = 4'hB;
        end
        fmt_frac = (frac_pos_q != 2'd0);
        fmt_dp   = fmt_frac ? (4'b0001 << frac_pos_q) : 4'b0000;
        if (fmt_ovf) begin
            fmt_bcd  = 16'hBBBB;
            fmt_dp   = 4'b0000;
            fmt_frac = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            val_q      <= 14'd0;
            neg_q      <= 1'b0;
            frac_pos_q <= 2'd0;
            sr_q       <= 16'd0;
            cnt_q      <= 4'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bcd_q      <= 16'hAAAA;
            dp_q       <= 4'b0000;
            frac_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        val_q      <= value;
                        neg_q      <= neg;
                        frac_pos_q <= frac_pos;
                        sr_q       <= 16'd0;
                        cnt_q      <= 4'd0;
                        busy_q     <= 1'b1;
                    end
                end
                StConv: begin
                    sr_q  <= sr_next;
                    cnt_q <= cnt_q + 4'd1;
                end
                StFmt: begin
                    bcd_q  <= fmt_bcd;
                    dp_q   <= fmt_dp;
                    frac_q <= fmt_frac;
                    ovf_q  <= fmt_ovf;
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bcd  = bcd_q;
    assign dp   = dp_q;
    assign frac = frac_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_disp_fmt.sv
// Bench for disp_fmt: both leading-zero modes side by side, directed cases
// plus random values compared against an arithmetic reference model.
module tb_disp_fmt;

    logic        clk, rst, start, neg;
    logic [13:0] value;
    logic [1:0]  frac_pos;
    logic        busy1, done1, frac1, ovf1;
    logic [15:0] bcd1;
    logic [3:0]  dp1;
    logic        busy0, done0, frac0, ovf0;
    logic [15:0] bcd0;
    logic [3:0]  dp0;

    int errors = 0;
    int checks = 0;

    disp_fmt #(.BLANK_LZ(1'b1)) u_blank (
        .clk(clk), .rst(rst), .start(start), .value(value), .neg(neg),
        .frac_pos(frac_pos), .busy(busy1), .done(done1), .bcd(bcd1), .dp(dp1),
        .frac(frac1), .ovf(ovf1)
    );

    disp_fmt #(.BLANK_LZ(1'b0)) u_zero (
        .clk(clk), .rst(rst), .start(start), .value(value), .neg(neg),
        .frac_pos(frac_pos), .busy(busy0), .done(done0), .bcd(bcd0), .dp(dp0),
        .frac(frac0), .ovf(ovf0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns {ovf, frac, dp[3:0], bcd[15:0]} from the display rules directly
    function automatic logic [21:0] model(input int v, input bit n, input int f, input bit blz);
        int d[4];
        int code[4];
        int t, top, keep;
        bit ne;
        logic [15:0] b;
        logic [3:0] dpv;
        if (v > 9999 || (n && v > 999) || (n && v != 0 && f == 3))
            return {1'b1, 1'b0, 4'b0000, 16'hBBBB};
        t = v;
        for (int i = 0; i < 4; i++) begin
            d[i] = t % 10;
            t = t / 10;
        end
        top = 0;
        for (int i = 0; i < 4; i++) if (d[i] != 0) top = i;
        keep = (top > f) ? top : f;
        ne = n && (v != 0);
        for (int i = 0; i < 4; i++) code[i] = (blz && i > keep) ? 10 : d[i];
        if (ne) begin
            if (blz) code[keep + 1] = 11;
            else     code[3] = 11;
        end
        for (int i = 0; i < 4; i++) b[i*4 +: 4] = 4'(code[i]);
        dpv = (f != 0) ? 4'(1 << f) : 4'b0000;
        return {1'b0, f != 0, dpv, b};
    endfunction

    task automatic check_out(input string tag, input int v, input bit n, input int f);
        logic [21:0] e1, e0;
        e1 = model(v, n, f, 1'b1);
        e0 = model(v, n, f, 1'b0);
        chk({tag, " bcd blank"}, 32'(bcd1), 32'(e1[15:0]));
        chk({tag, " dp blank"}, 32'(dp1), 32'(e1[19:16]));
        chk({tag, " frac blank"}, 32'(frac1), 32'(e1[20]));
        chk({tag, " ovf blank"}, 32'(ovf1), 32'(e1[21]));
        chk({tag, " bcd zero"}, 32'(bcd0), 32'(e0[15:0]));
        chk({tag, " dp zero"}, 32'(dp0), 32'(e0[19:16]));
        chk({tag, " frac zero"}, 32'(frac0), 32'(e0[20]));
        chk({tag, " ovf zero"}, 32'(ovf0), 32'(e0[21]));
    endtask

    // Start on the next edge, wait (bounded) for done, check latency and result
    task automatic run(input string tag, input int v, input bit n, input int f);
        int lat;
        bit stable;
        logic [15:0] held;
        value = 14'(v); neg = n; frac_pos = 2'(f); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, " busy after start"}, 32'(busy1), 32'd1);
        held = bcd1;
        stable = 1'b1;
        lat = 0;
        while (!done1 && lat < 40) begin
            if (bcd1 !== held) stable = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, " latency"}, 32'(lat), 32'd15);
        chk({tag, " outputs held"}, 32'(stable), 32'd1);
        chk({tag, " done both"}, 32'(done0), 32'd1);
        chk({tag, " busy at done"}, 32'(busy1), 32'd0);
        check_out(tag, v, n, f);
    endtask

    initial begin
        int v, dn, lat;
        rst = 1'b1; start = 1'b1; value = 14'd77; neg = 1'b0; frac_pos = 2'd1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; start = 1'b0;
        chk("reset busy", 32'(busy1), 32'd0);
        chk("reset done", 32'(done1), 32'd0);
        chk("reset bcd", 32'(bcd1), 32'hAAAA);
        chk("reset bcd zero", 32'(bcd0), 32'hAAAA);
        chk("reset dp", 32'(dp1), 32'd0);
        chk("reset frac", 32'(frac1), 32'd0);
        chk("reset ovf", 32'(ovf1), 32'd0);
        @(posedge clk); #1;
        chk("start ignored in reset", 32'(busy1), 32'd0);

        run("1234", 1234, 1'b0, 0);
        chk("1234 literal", 32'(bcd1), 32'h1234);
        run("5 f2", 5, 1'b0, 2);
        chk("5 f2 literal", 32'(bcd1), 32'hA005);
        chk("5 f2 dp literal", 32'(dp1), 32'b0100);
        run("neg zero", 0, 1'b1, 0);
        chk("neg zero literal", 32'(bcd1), 32'hAAA0);
        run("-42", 42, 1'b1, 0);
        chk("-42 blank literal", 32'(bcd1), 32'hAB42);
        chk("-42 zero literal", 32'(bcd0), 32'hB042);
        run("10000", 10000, 1'b0, 0);
        chk("10000 literal", 32'(bcd1), 32'hBBBB);
        run("-1000", 1000, 1'b1, 0);
        run("9999", 9999, 1'b0, 1);
        run("-999 f2", 999, 1'b1, 2);
        run("-1 f3", 1, 1'b1, 3);
        run("0 f3", 0, 1'b1, 3);
        run("16383", 16383, 1'b0, 0);

        // Start pulsed mid-conversion with a different value: must be ignored
        value = 14'd321; neg = 1'b0; frac_pos = 2'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        value = 14'd8888; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 6;
        while (!done1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("mid start latency", 32'(lat), 32'd15);
        check_out("mid start", 321, 1'b0, 1);
        dn = 0;
        repeat (25) begin
            @(posedge clk); #1;
            if (done1) dn++;
        end
        chk("mid start single done", 32'(dn), 32'd0);

        // Back-to-back: second start lands in the done cycle of the first
        run("b2b first", 57, 1'b0, 0);
        run("b2b second", 603, 1'b1, 1);

        // Reset at iteration 7 aborts with no done
        value = 14'd4321; neg = 1'b0; frac_pos = 2'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort busy", 32'(busy1), 32'd0);
        chk("abort bcd", 32'(bcd1), 32'hAAAA);
        chk("abort done", 32'(done1), 32'd0);
        dn = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done1) dn++;
        end
        chk("abort no done", 32'(dn), 32'd0);
        run("after abort", 4321, 1'b0, 0);

        for (int k = 0; k < 40; k++) begin
            v = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 1200))
                                            : int'($urandom_range(0, 16383));
            run($sformatf("rand%0d v=%0d", k, v), v, 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
